// File: rtl/leaf_pkt_pkg.sv
// Shared definitions for the leaf output scheduler: packet field positions,
// scheduler FSM states and credit counter sizing.
package leaf_pkt_pkg;

  localparam int unsigned VALID_BIT = 48;
  localparam int unsigned LEAF_LSB  = 43;
  localparam int unsigned PORT_LSB  = 39;
  localparam int unsigned ADDR_LSB  = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } sched_state_e;

  // One extra bit so a full buffer (2^bram_addr_bits words) is representable.
  function automatic int unsigned credit_w(input int unsigned bram_addr_bits);
    return bram_addr_bits + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after i_ptr wins.
module rr_arbiter #(
  parameter  int unsigned N  = 7,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_winner,
  output logic          o_any
);

  int unsigned   w_sum;
  logic [IW-1:0] w_idx;

  always_comb begin
    o_grant  = '0;
    o_winner = '0;
    o_any    = 1'b0;
    w_sum    = 0;
    w_idx    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_sum = 32'(i_ptr) + k;
      if (w_sum >= N) w_sum = w_sum - N;
      w_idx = IW'(w_sum);
      if (!o_any && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        o_winner       = w_idx;
        o_any          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/leaf_out_scheduler.sv
// Per-leaf output scheduler: round-robin over credited user output streams,
// packing each accepted word into a BFT packet with destination and address.
module leaf_out_scheduler
  import leaf_pkt_pkg::*;
#(
  parameter int unsigned PACKET_BITS           = 49,
  parameter int unsigned PAYLOAD_BITS          = 32,
  parameter int unsigned NUM_LEAF_BITS         = 5,
  parameter int unsigned NUM_PORT_BITS         = 4,
  parameter int unsigned NUM_ADDR_BITS         = 7,
  parameter int unsigned NUM_OUT_PORTS         = 7,
  parameter int unsigned NUM_BRAM_ADDR_BITS    = 7,
  parameter int unsigned FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_OUT_PORTS-1:0]               vld_user2interface,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]  din_leaf_user2interface,
  output logic [NUM_OUT_PORTS-1:0]               ack_interface2user,
  input  logic                                   cfg_we,
  input  logic [NUM_PORT_BITS-1:0]               cfg_port,
  input  logic [NUM_LEAF_BITS+NUM_PORT_BITS-1:0] cfg_dest,
  input  logic                                   credit_vld,
  input  logic [NUM_PORT_BITS-1:0]               credit_port,
  input  logic                                   resend,
  output logic [PACKET_BITS-1:0]                 pkt_out,
  input  logic                                   pkt_rdy
);

  localparam int unsigned DEST_BITS  = NUM_LEAF_BITS + NUM_PORT_BITS;
  localparam int unsigned CW         = credit_w(NUM_BRAM_ADDR_BITS);
  localparam int unsigned SW         = CW + 1;
  localparam int unsigned CREDIT_MAX = 1 << NUM_BRAM_ADDR_BITS;
  localparam int unsigned PW         = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;

  sched_state_e             r_state, w_state_nxt;
  logic                     w_sched_en;
  logic [NUM_OUT_PORTS-1:0] r_cfgd;
  logic [DEST_BITS-1:0]     r_dest    [NUM_OUT_PORTS];
  logic [CW-1:0]            r_credit  [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] r_wr_addr [NUM_OUT_PORTS];
  logic [PW-1:0]            r_rr_ptr;
  logic [PACKET_BITS-1:0]   r_pkt;

  logic [NUM_OUT_PORTS-1:0] w_cfg_hit, w_credit_hit, w_req, w_grant;
  logic [PW-1:0]            w_winner;
  logic                     w_any, w_slot_free;
  logic [PAYLOAD_BITS-1:0]  w_sel_data;
  logic [DEST_BITS-1:0]     w_sel_dest;
  logic [NUM_ADDR_BITS-1:0] w_sel_addr;
  logic [CW-1:0]            w_credit_nxt [NUM_OUT_PORTS];
  logic [SW-1:0]            w_sum;

  // Out-of-range cfg/credit port numbers never match, so they are dropped here.
  always_comb begin
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      w_cfg_hit[i]    = cfg_we && (cfg_port == NUM_PORT_BITS'(i));
      w_credit_hit[i] = credit_vld && (credit_port == NUM_PORT_BITS'(i));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sched_en  = 1'b0;
    case (r_state)
      IDLE: if (|w_cfg_hit) w_state_nxt = RUN;
      RUN: begin
        w_sched_en = !resend;
        if (resend) w_state_nxt = HOLD;
      end
      HOLD:    if (!resend) w_state_nxt = RUN;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_slot_free = !r_pkt[VALID_BIT] || pkt_rdy;

  always_comb begin
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      w_req[i] = vld_user2interface[i] && r_cfgd[i] && (r_credit[i] != '0) &&
                 !w_cfg_hit[i] && w_sched_en && w_slot_free;
    end
  end

  rr_arbiter #(.N(NUM_OUT_PORTS)) u_arb (
    .i_req    (w_req),
    .i_ptr    (r_rr_ptr),
    .o_grant  (w_grant),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  assign ack_interface2user = w_grant;

  always_comb begin
    w_sel_data = '0;
    w_sel_dest = '0;
    w_sel_addr = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      if (w_grant[i]) begin
        w_sel_data = din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS];
        w_sel_dest = r_dest[i];
        w_sel_addr = r_wr_addr[i];
      end
    end
  end

  // Grant and freespace return net together before saturating; cfg reload wins.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      w_sum = {1'b0, r_credit[i]} - SW'(w_grant[i]) +
              (w_credit_hit[i] ? SW'(FREESPACE_UPDATE_SIZE) : SW'(0));
      if (w_sum > SW'(CREDIT_MAX)) w_sum = SW'(CREDIT_MAX);
      w_credit_nxt[i] = w_cfg_hit[i] ? CW'(CREDIT_MAX) : w_sum[CW-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cfgd <= '0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        r_dest[i]    <= '0;
        r_credit[i]  <= CW'(CREDIT_MAX);
        r_wr_addr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        r_credit[i] <= w_credit_nxt[i];
        if (w_cfg_hit[i]) begin
          r_cfgd[i]    <= 1'b1;
          r_dest[i]    <= cfg_dest;
          r_wr_addr[i] <= '0;
        end else if (w_grant[i]) begin
          r_wr_addr[i] <= r_wr_addr[i] + NUM_ADDR_BITS'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr <= '0;
      r_pkt    <= '0;
    end else if (w_any) begin
      r_rr_ptr <= (32'(w_winner) == NUM_OUT_PORTS - 1) ? '0 : w_winner + PW'(1);
      r_pkt    <= {1'b1, w_sel_dest, w_sel_addr, w_sel_data};
    end else if (pkt_rdy) begin
      r_pkt[VALID_BIT] <= 1'b0;
    end
  end

  assign pkt_out = r_pkt;

endmodule

// File: tb/tb_leaf_out_scheduler.sv
// Bench for leaf_out_scheduler: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_leaf_out_scheduler;
  import leaf_pkt_pkg::*;

  localparam int NP = 7;

  logic         clk = 1'b0;
  logic         reset;
  logic [6:0]   vld;
  logic [223:0] din;
  logic [6:0]   ack;
  logic         cfg_we;
  logic [3:0]   cfg_port;
  logic [8:0]   cfg_dest;
  logic         credit_vld;
  logic [3:0]   credit_port;
  logic         resend;
  logic [48:0]  pkt_out;
  logic         pkt_rdy;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  leaf_out_scheduler dut (
    .clk                     (clk),
    .reset                   (reset),
    .vld_user2interface      (vld),
    .din_leaf_user2interface (din),
    .ack_interface2user      (ack),
    .cfg_we                  (cfg_we),
    .cfg_port                (cfg_port),
    .cfg_dest                (cfg_dest),
    .credit_vld              (credit_vld),
    .credit_port             (credit_port),
    .resend                  (resend),
    .pkt_out                 (pkt_out),
    .pkt_rdy                 (pkt_rdy)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
  endtask

  // Behavioural model state
  bit          m_cfgd   [NP];
  logic [8:0]  m_dest   [NP];
  int          m_credit [NP];
  int          m_addr   [NP];
  int          m_rr;
  bit          m_started;
  bit          m_hold;
  logic [48:0] m_pkt;

  task automatic m_reset();
    for (int p = 0; p < NP; p++) begin
      m_cfgd[p]   = 1'b0;
      m_dest[p]   = '0;
      m_credit[p] = 128;
      m_addr[p]   = 0;
    end
    m_rr      = 0;
    m_started = 1'b0;
    m_hold    = 1'b0;
    m_pkt     = '0;
  endtask

  always @(negedge clk) begin
    logic [6:0] e_ack;
    int         win;
    int         p;
    bit         slot;
    if (reset) begin
      m_reset();
      check("reset_ack", 64'(ack), 64'(m_pkt[6:0]));
      check("reset_pkt", 64'(pkt_out), 64'(m_pkt));
    end else begin
      slot  = !m_pkt[48] || pkt_rdy;
      win   = -1;
      e_ack = '0;
      if (!m_hold && !resend && slot) begin
        for (int k = 0; k < NP; k++) begin
          p = (m_rr + k) % NP;
          if (win < 0 && vld[p] && m_cfgd[p] && m_credit[p] > 0 &&
              !(cfg_we && int'(cfg_port) == p))
            win = p;
        end
      end
      if (win >= 0) e_ack[win] = 1'b1;
      check("ack", 64'(ack), 64'(e_ack));
      check("pkt_out", 64'(pkt_out), 64'(m_pkt));
      if (win >= 0) begin
        m_pkt = {1'b1, m_dest[win], 7'(m_addr[win]), din[win*32 +: 32]};
        m_addr[win] = (m_addr[win] + 1) % 128;
        m_credit[win] = m_credit[win] - 1;
        m_rr = (win + 1) % NP;
      end else if (pkt_rdy) begin
        m_pkt[48] = 1'b0;
      end
      if (credit_vld && int'(credit_port) < NP) begin
        m_credit[credit_port] = m_credit[credit_port] + 64;
        if (m_credit[credit_port] > 128) m_credit[credit_port] = 128;
      end
      m_hold = resend && m_started;
      if (cfg_we && int'(cfg_port) < NP) begin
        m_cfgd[cfg_port]   = 1'b1;
        m_dest[cfg_port]   = cfg_dest;
        m_credit[cfg_port] = 128;
        m_addr[cfg_port]   = 0;
        m_started          = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int p, input logic [31:0] w);
    din[p*32 +: 32] = w;
  endtask

  task automatic cfg(input int p, input logic [4:0] leaf, input logic [3:0] port);
    cfg_we   = 1'b1;
    cfg_port = 4'(p);
    cfg_dest = {leaf, port};
    tick();
    cfg_we   = 1'b0;
  endtask

  initial begin
    int cnt;
    int exp_p;
    reset = 1'b1; vld = '0; din = '0; cfg_we = 1'b0; cfg_port = '0; cfg_dest = '0;
    credit_vld = 1'b0; credit_port = '0; resend = 1'b0; pkt_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("lit_reset_pkt", 64'(pkt_out), 64'(0));
    check("lit_reset_ack", 64'(ack), 64'(0));
    reset = 1'b0;
    tick();

    // First packet and address increment
    cfg(0, 5'd3, 4'd2);
    vld = 7'b0000001; set_word(0, 32'hDEADBEEF); pkt_rdy = 1'b1;
    #2 check("a_ack0", 64'(ack), 64'(1));
    tick();
    check("a_pkt0", 64'(pkt_out), 64'({1'b1, 5'd3, 4'd2, 7'd0, 32'hDEADBEEF}));
    set_word(0, 32'h12345678);
    tick();
    check("a_pkt1_addr", 64'(pkt_out[ADDR_LSB +: 7]), 64'(1));
    vld = '0;

    // Round-robin over ports 0, 2, 5 starting after port 0
    cfg(2, 5'd1, 4'd1);
    cfg(5, 5'd2, 4'd3);
    vld = 7'b0100101;
    for (int k = 0; k < 6; k++) begin
      exp_p = (k % 3 == 0) ? 2 : ((k % 3 == 1) ? 5 : 0);
      #2 check("b_rr_order", 64'(ack), 64'(7'(1 << exp_p)));
      tick();
    end
    vld = '0;

    // Output hold under back-pressure
    vld = 7'b0000001;
    #2 check("d_grant", 64'(ack), 64'(1));
    tick();
    pkt_rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #2 check("d_hold_ack", 64'(ack), 64'(0));
      check("d_hold_pkt", 64'(pkt_out), 64'({1'b1, 5'd3, 4'd2, 7'd4, 32'h12345678}));
      tick();
    end
    pkt_rdy = 1'b1;
    #2 check("d_release_ack", 64'(ack), 64'(1));
    tick();
    vld = '0;

    // Resend pause and resume at preserved pointer
    vld = 7'b0100101;
    tick(); tick();
    resend = 1'b1; pkt_rdy = 1'b0;
    #2 check("e_resend_ack", 64'(ack), 64'(0));
    tick();
    for (int k = 0; k < 3; k++) begin
      pkt_rdy = (k > 0);
      #2 check("e_resend_ack", 64'(ack), 64'(0));
      tick();
    end
    resend = 1'b0;
    #2 check("e_hold_exit_ack", 64'(ack), 64'(0));
    tick();
    #2 check("e_resume_ack", 64'(ack), 64'(1));
    tick();
    vld = '0;

    // Reconfiguration suppresses same-cycle grant
    vld = 7'b0000001; set_word(0, 32'hCAFEF00D);
    cfg_we = 1'b1; cfg_port = 4'd0; cfg_dest = {5'd7, 4'd9};
    #2 check("f_cfg_suppress", 64'(ack), 64'(0));
    tick();
    cfg_we = 1'b0;
    #2 check("f_ack_after_cfg", 64'(ack), 64'(1));
    tick();
    check("f_pkt_newdest", 64'(pkt_out), 64'({1'b1, 5'd7, 4'd9, 7'd0, 32'hCAFEF00D}));
    vld = '0;

    // Credit exhaustion, return and address wrap
    cfg(1, 5'd4, 4'd1);
    vld = 7'b0000010; cnt = 0;
    for (int k = 0; k < 140; k++) begin
      #2 if (ack[1]) cnt++;
      tick();
    end
    check("c_acks_128", 64'(cnt), 64'(128));
    credit_vld = 1'b1; credit_port = 4'd1; cnt = 0;
    #2 if (ack[1]) cnt++;
    tick();
    credit_vld = 1'b0;
    for (int k = 0; k < 80; k++) begin
      #2 if (ack[1]) cnt++;
      tick();
    end
    check("c_acks_64", 64'(cnt), 64'(64));
    check("c_addr_wrap", 64'(pkt_out[ADDR_LSB +: 7]), 64'(63));
    vld = '0;

    // Randomized traffic with one mid-stream reset
    for (int c = 0; c < 3000; c++) begin
      vld = 7'($urandom);
      for (int p = 0; p < NP; p++) set_word(p, $urandom);
      cfg_we      = ($urandom_range(0, 15) == 0);
      cfg_port    = 4'($urandom_range(0, 8));
      cfg_dest    = 9'($urandom);
      credit_vld  = ($urandom_range(0, 5) == 0);
      credit_port = 4'($urandom_range(0, 8));
      if ($urandom_range(0, 19) == 0) resend = ~resend;
      pkt_rdy     = ($urandom_range(0, 3) != 0);
      reset       = (c == 1500 || c == 1501);
      tick();
    end
    vld = '0; cfg_we = 1'b0; credit_vld = 1'b0; resend = 1'b0; pkt_rdy = 1'b1; reset = 1'b0;
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
